// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: fetch/decode/exec/mem/writeback sequencing with memory timeout and halt handling.
// Optional retired-instruction counter output is enabled by defining MCTRL_RETIRE_CNT_EN.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int RETIRE_W    = 16
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic [7:0] InsM,
  input  logic [1:0] InsL,
  input  logic [2:0] PSW_NZC,
  input  logic       mem_ack,
  input  logic       Resume,
  output logic       mem_req,
  output logic       Buff_MEMIns,
  output logic       WE_MEM,
  output logic       WE_RF,
  output logic       Buff_PSW,
  output logic [1:0] ALUop,
  output logic       Branch,
  output logic [1:0] Jump,
  output logic       PCplus1orWB,
  output logic       Buff_PC,
  output logic       Done,
  output logic       out_strobe,
  output logic       Halted,
  output logic       Illegal,
  output logic       BusErr,
  output logic [2:0] stage
`ifdef MCTRL_RETIRE_CNT_EN
  ,
  output logic [RETIRE_W-1:0] retired
`endif
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
    S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
  } state_e;

  typedef enum logic [4:0] {
    C_ALU, C_LHI, C_LLI, C_LDR, C_STR, C_CMP, C_ADDI, C_SUBI, C_MOV,
    C_BCOND, C_BAL, C_JMP, C_JALRL, C_JALRR, C_JR, C_OUTR, C_HLT, C_ILL
  } cls_e;

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_e        state_q;
  logic [7:0]    ins_m_q;
  logic [1:0]    ins_l_q;
  logic [TW-1:0] wait_q;
  logic          illegal_q;
  logic          buserr_q;
  cls_e          cls;
  logic          cond_true;
  logic          timeout_hit;

  always_comb begin
    cls = C_ILL;
    case (ins_m_q[7:3])
      5'b00000: cls = C_ALU;
      5'b00001: cls = C_LHI;
      5'b00010: cls = C_LLI;
      5'b00011: cls = C_LDR;
      5'b00100: cls = C_LDR;
      5'b00101: cls = C_STR;
      5'b00110: cls = (ins_l_q == 2'b00) ? C_STR : ((ins_l_q == 2'b01) ? C_CMP : C_ILL);
      5'b00111: cls = C_ADDI;
      5'b01000: cls = C_SUBI;
      5'b01011: cls = C_MOV;
      5'b11000: cls = (ins_m_q[2:1] == 2'b11) ? C_ILL : C_BCOND;
      5'b11001: cls = C_BAL;
      5'b10000: cls = C_JMP;
      5'b10001: cls = C_JALRL;
      5'b10010: cls = C_JALRR;
      5'b10011: cls = C_JR;
      5'b11100: cls = (ins_l_q == 2'b00) ? C_OUTR : ((ins_l_q == 2'b01) ? C_HLT : C_ILL);
      default:  cls = C_ILL;
    endcase
  end

  // Condition codes index PSW_NZC as {N,Z,C}.
  always_comb begin
    cond_true = 1'b0;
    case (ins_m_q[2:0])
      3'd0:    cond_true = ~PSW_NZC[1];
      3'd1:    cond_true =  PSW_NZC[1];
      3'd2:    cond_true =  PSW_NZC[0];
      3'd3:    cond_true = ~PSW_NZC[0];
      3'd4:    cond_true =  PSW_NZC[2];
      3'd5:    cond_true = ~PSW_NZC[2];
      default: cond_true = 1'b0;
    endcase
  end

  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == TW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q   <= S_FETCH;
      ins_m_q   <= '0;
      ins_l_q   <= '0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      buserr_q  <= 1'b0;
    end else begin
      wait_q <= '0;
      case (state_q)
        S_FETCH: begin
          if (mem_ack) begin
            ins_m_q <= InsM;
            ins_l_q <= InsL;
            state_q <= S_DECODE;
          end else if (timeout_hit) begin
            buserr_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            wait_q <= wait_q + TW'(1);
          end
        end
        S_DECODE: begin
          if (cls == C_HLT) begin
            state_q <= S_HALT;
          end else if (cls == C_ILL) begin
            illegal_q <= 1'b1;
            state_q   <= S_HALT;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (cls)
            C_LDR, C_STR: state_q <= S_MEM;
            C_ALU, C_LHI, C_LLI, C_ADDI, C_SUBI, C_MOV, C_JALRL, C_JALRR: state_q <= S_WB;
            default: state_q <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (mem_ack) begin
            state_q <= (cls == C_LDR) ? S_WB : S_FETCH;
          end else if (timeout_hit) begin
            buserr_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            wait_q <= wait_q + TW'(1);
          end
        end
        S_WB: state_q <= S_FETCH;
        S_HALT: begin
          if (Resume && !illegal_q && !buserr_q) state_q <= S_FETCH;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Strobes are decoded from the current state; Rst forces everything quiet.
  always_comb begin
    mem_req     = 1'b0;
    Buff_MEMIns = 1'b0;
    WE_MEM      = 1'b0;
    WE_RF       = 1'b0;
    Buff_PSW    = 1'b0;
    ALUop       = 2'b00;
    Branch      = 1'b0;
    Jump        = 2'b00;
    PCplus1orWB = 1'b0;
    Buff_PC     = 1'b0;
    out_strobe  = 1'b0;
    if (!Rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req     = 1'b1;
          Buff_MEMIns = mem_ack;
        end
        S_EXEC: begin
          case (cls)
            C_ALU:         begin Buff_PSW = 1'b1; ALUop = ins_l_q; end
            C_ADDI:        Buff_PSW = 1'b1;
            C_SUBI:        begin Buff_PSW = 1'b1; ALUop = 2'b10; end
            C_CMP:         begin Buff_PSW = 1'b1; ALUop = 2'b10; Buff_PC = 1'b1; end
            C_BCOND:       begin Branch = cond_true; Buff_PC = 1'b1; end
            C_BAL:         begin Branch = 1'b1; Buff_PC = 1'b1; end
            C_JMP:         begin Jump = 2'b01; Buff_PC = 1'b1; end
            C_JALRL:       Jump = 2'b01;
            C_JALRR:       Jump = 2'b10;
            C_JR:          begin Jump = 2'b10; Buff_PC = 1'b1; end
            C_OUTR:        begin out_strobe = 1'b1; Buff_PC = 1'b1; end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          WE_MEM  = (cls == C_STR);
          Buff_PC = (cls == C_STR) && mem_ack;
        end
        S_WB: begin
          WE_RF       = 1'b1;
          Buff_PC     = 1'b1;
          PCplus1orWB = (cls == C_JALRL) || (cls == C_JALRR);
        end
        default: ;
      endcase
    end
  end

  assign Done    = Buff_PC;
  assign Halted  = !Rst && (state_q == S_HALT);
  assign Illegal = !Rst && illegal_q;
  assign BusErr  = !Rst && buserr_q;
  assign stage   = Rst ? 3'd0 : state_q;

`ifdef MCTRL_RETIRE_CNT_EN
  logic [RETIRE_W-1:0] retired_q;
  always_ff @(posedge clk) begin
    if (Rst) retired_q <= '0;
    else if (Done) retired_q <= retired_q + RETIRE_W'(1);
  end
  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle output trace predicted from instruction-level sequence rules.
module tb_multicycle_ctrl;
  localparam int TMO = 15;
  localparam int K_ALU = 0, K_LHI = 1, K_LLI = 2, K_LDR = 3, K_STR = 4, K_CMP = 5, K_ADDI = 6,
                 K_SUBI = 7, K_MOV = 8, K_BC = 9, K_BAL = 10, K_JMP = 11, K_JALRL = 12,
                 K_JALRR = 13, K_JR = 14, K_OUT = 15, K_HLT = 16, K_ILL = 17;

  typedef struct packed {
    logic [2:0] stage;
    logic       mem_req, ins, we_mem, we_rf, psw;
    logic [1:0] aluop;
    logic       br;
    logic [1:0] jmp;
    logic       link, pc, done, outs, halted, ill, berr;
  } out_t;

  logic clk = 1'b0;
  logic Rst = 1'b1;
  logic [7:0] InsM = '0;
  logic [1:0] InsL = '0;
  logic [2:0] PSW_NZC = '0;
  logic mem_ack = 1'b0, Resume = 1'b0;
  logic mem_req, Buff_MEMIns, WE_MEM, WE_RF, Buff_PSW, Branch, PCplus1orWB, Buff_PC, Done;
  logic out_strobe, Halted, Illegal, BusErr;
  logic [1:0] ALUop, Jump;
  logic [2:0] stage;
`ifdef MCTRL_RETIRE_CNT_EN
  logic [15:0] retired;
`endif

  int checks = 0;
  int errors = 0;
  int rexp = 0;
  out_t exp_q[$];
  bit   ack_q[$];
  bit   res_q[$];
  logic [4:0] legal_op [17];

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(TMO), .RETIRE_W(16)) dut (
    .clk(clk), .Rst(Rst), .InsM(InsM), .InsL(InsL), .PSW_NZC(PSW_NZC), .mem_ack(mem_ack),
    .Resume(Resume), .mem_req(mem_req), .Buff_MEMIns(Buff_MEMIns), .WE_MEM(WE_MEM), .WE_RF(WE_RF),
    .Buff_PSW(Buff_PSW), .ALUop(ALUop), .Branch(Branch), .Jump(Jump), .PCplus1orWB(PCplus1orWB),
    .Buff_PC(Buff_PC), .Done(Done), .out_strobe(out_strobe), .Halted(Halted), .Illegal(Illegal),
    .BusErr(BusErr), .stage(stage)
`ifdef MCTRL_RETIRE_CNT_EN
    , .retired(retired)
`endif
  );

  function automatic int kind_of(input logic [7:0] im, input logic [1:0] il);
    case (im[7:3])
      5'b00000: return K_ALU;
      5'b00001: return K_LHI;
      5'b00010: return K_LLI;
      5'b00011, 5'b00100: return K_LDR;
      5'b00101: return K_STR;
      5'b00110: return (il == 2'd0) ? K_STR : ((il == 2'd1) ? K_CMP : K_ILL);
      5'b00111: return K_ADDI;
      5'b01000: return K_SUBI;
      5'b01011: return K_MOV;
      5'b11000: return (im[2:0] > 3'd5) ? K_ILL : K_BC;
      5'b11001: return K_BAL;
      5'b10000: return K_JMP;
      5'b10001: return K_JALRL;
      5'b10010: return K_JALRR;
      5'b10011: return K_JR;
      5'b11100: return (il == 2'd0) ? K_OUT : ((il == 2'd1) ? K_HLT : K_ILL);
      default:  return K_ILL;
    endcase
  endfunction

  function automatic logic taken(input logic [2:0] c, input logic [2:0] nzc);
    logic n, z, cf;
    {n, z, cf} = nzc;
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return cf;
      3'd3: return !cf;
      3'd4: return n;
      default: return !n;
    endcase
  endfunction

  task automatic push(input out_t e, input bit a, input bit r);
    exp_q.push_back(e);
    ack_q.push_back(a);
    res_q.push_back(r);
  endtask

  // Expected trace of one instruction from its stage sequence: df fetch waits, dm memory waits.
  task automatic model(input logic [7:0] im, input logic [1:0] il, input logic [2:0] nzc,
                       input int df, input int dm);
    int k;
    out_t e;
    k = kind_of(im, il);
    for (int i = 0; i <= df; i++) begin
      e = '0; e.mem_req = 1'b1; e.ins = (i == df);
      push(e, i == df, 1'b0);
    end
    e = '0; e.stage = 3'd1;
    if (k == K_HLT) push(e, 1'b1, 1'b1);
    else push(e, 1'($urandom), 1'($urandom));
    if (k == K_HLT || k == K_ILL) begin
      e = '0; e.stage = 3'd5; e.halted = 1'b1; e.ill = (k == K_ILL);
      push(e, 1'($urandom), 1'b0);
      push(e, 1'($urandom), 1'b1);
      return;
    end
    e = '0; e.stage = 3'd2;
    case (k)
      K_ALU:  begin e.psw = 1'b1; e.aluop = il; end
      K_ADDI: e.psw = 1'b1;
      K_SUBI, K_CMP: begin e.psw = 1'b1; e.aluop = 2'b10; end
      K_BC:   e.br = taken(im[2:0], nzc);
      K_BAL:  e.br = 1'b1;
      K_JMP, K_JALRL: e.jmp = 2'b01;
      K_JALRR, K_JR:  e.jmp = 2'b10;
      K_OUT:  e.outs = 1'b1;
      default: ;
    endcase
    if (k inside {K_CMP, K_BC, K_BAL, K_JMP, K_JR, K_OUT}) begin e.pc = 1'b1; e.done = 1'b1; end
    push(e, 1'($urandom), 1'b0);
    if (k == K_LDR || k == K_STR) begin
      for (int j = 0; j <= dm; j++) begin
        e = '0; e.stage = 3'd3; e.mem_req = 1'b1; e.we_mem = (k == K_STR);
        e.pc = (k == K_STR) && (j == dm); e.done = e.pc;
        push(e, j == dm, 1'b0);
      end
    end
    if (k inside {K_ALU, K_ADDI, K_SUBI, K_MOV, K_LHI, K_LLI, K_JALRL, K_JALRR, K_LDR}) begin
      e = '0; e.stage = 3'd4; e.we_rf = 1'b1; e.pc = 1'b1; e.done = 1'b1;
      e.link = (k == K_JALRL) || (k == K_JALRR);
      push(e, 1'($urandom), 1'b0);
    end
  endtask

  task automatic check(input out_t e, input string tag, input int cyc);
    out_t o;
    o = {stage, mem_req, Buff_MEMIns, WE_MEM, WE_RF, Buff_PSW, ALUop, Branch, Jump,
         PCplus1orWB, Buff_PC, Done, out_strobe, Halted, Illegal, BusErr};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed=%h expected=%h", tag, cyc, o, e);
    end
  endtask

  // Plays queued cycles; at abort_at Rst is pulsed and the rest of the instruction is dropped.
  task automatic run(input logic [7:0] im, input logic [1:0] il, input logic [2:0] nzc,
                     input int df, input int abort_at, input string tag);
    int k;
    out_t e;
    bit a, r;
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = ack_q.pop_front(); r = res_q.pop_front();
      @(negedge clk);
      Rst     = (k == abort_at);
      mem_ack = a;
      Resume  = r;
      InsM    = (k == df) ? im : 8'($urandom);
      InsL    = (k == df) ? il : 2'($urandom);
      PSW_NZC = (k == df + 2) ? nzc : 3'($urandom);
      #1;
      if (k == abort_at) e = '0;
      check(e, tag, k + 1);
      if (e.done) rexp = (rexp + 1) % 65536;
      if (k == abort_at) begin
        rexp = 0;
        exp_q.delete(); ack_q.delete(); res_q.delete();
      end
      k++;
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      Rst = 1'b1; mem_ack = 1'b1; Resume = 1'b1; InsM = 8'($urandom);
      #1;
      check('0, "reset", i);
    end
    rexp = 0;
  endtask

  task automatic instr(input logic [7:0] im, input logic [1:0] il, input logic [2:0] nzc,
                       input int df, input int dm, input string tag);
    model(im, il, nzc, df, dm);
    run(im, il, nzc, df, -1, tag);
  endtask

  initial begin
    logic [7:0] im;
    logic [1:0] il;
    logic [4:0] op;
    out_t e;
    legal_op = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
                 5'b00111, 5'b01000, 5'b01011, 5'b11000, 5'b11001, 5'b10000, 5'b10001,
                 5'b10010, 5'b10011, 5'b11100};
    do_reset(3);
    instr(8'b00000_101, 2'b00, 3'($urandom), 0, 0, "add");
    instr(8'b11000_001, 2'b00, 3'b010, 0, 0, "beq_taken");
    instr(8'b11000_001, 2'b00, 3'b000, 0, 0, "beq_not_taken");
    instr(8'b00101_011, 2'b10, 3'($urandom), 0, 3, "strri_wait3");
    // Rst in the second MEM wait cycle of an LDR (F,F,D,E,M,M...).
    model(8'b00011_000, 2'b00, 3'b000, 1, 6);
    run(8'b00011_000, 2'b00, 3'b000, 1, 5, "ldr_abort");
    instr(8'b01011_010, 2'b01, 3'($urandom), 0, 0, "mov_after_abort");
    do_reset(1);
    for (int n = 0; n < 28; n++) begin
      op = legal_op[$urandom_range(0, 16)];
      im = {op, 3'($urandom)};
      il = 2'($urandom);
      if (op == 5'b11000) im[2:0] = 3'($urandom_range(0, 5));
      if (op == 5'b00110) il = 2'($urandom_range(0, 1));
      if (op == 5'b11100) il = 2'b00;
      instr(im, il, 3'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), "random");
    end
`ifdef MCTRL_RETIRE_CNT_EN
    checks++;
    assert (int'(retired) === rexp) else begin
      errors++;
      $error("FAIL retired: observed=%0d expected=%0d", retired, rexp);
    end
`endif
    instr(8'b11100_110, 2'b01, 3'($urandom), 1, 0, "hlt_resume");
    instr(8'b10001_000, 2'b11, 3'($urandom), 0, 0, "jalrl_after_resume");
    instr(8'b11111_010, 2'b00, 3'($urandom), 0, 0, "illegal_op");
    do_reset(1);
    instr(8'b11000_110, 2'b00, 3'($urandom), 0, 0, "illegal_cond");
    do_reset(1);
    for (int i = 0; i < TMO; i++) begin
      e = '0; e.mem_req = 1'b1;
      push(e, 1'b0, 1'b0);
    end
    e = '0; e.stage = 3'd5; e.halted = 1'b1; e.berr = 1'b1;
    push(e, 1'b0, 1'b1);
    push(e, 1'b1, 1'b0);
    run(8'h00, 2'b00, 3'b000, -1, -1, "fetch_timeout");
    do_reset(1);
    instr(8'b00111_001, 2'b00, 3'($urandom), 2, 0, "addi_after_buserr");
    instr(8'b00100_001, 2'b00, 3'($urandom), 0, 2, "ldrrr_wait2");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
